// File: rtl/dout_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dout_uart_tx
//  Purpose  : Captures CPU output bytes (Dout/Dval rising edge) into a small
//             FIFO and streams them out as asynchronous serial frames on Tx.
//             Default framing is 8N1. Defining the macro PARITY_EN inserts an
//             even-parity bit after the data bits (8E1).
//  Revision : 1.0 - initial release
// ============================================================================
module dout_uart_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [7:0]               Dout,
  input  logic                     Dval,
  output logic                     Tx,
  output logic                     Busy,
  output logic                     Overflow,
  output logic [$clog2(DEPTH):0]   Count
);

  // Clocks per serial bit and derived widths.
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            busy_q;
  logic            overflow_q;
  logic            dval_q;
`ifdef PARITY_EN
  logic            par_q;
`endif

  logic [7:0]      mem_q [DEPTH];
  logic [AW:0]     wptr_q;
  logic [AW:0]     rptr_q;

  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  logic            w_wr;
  logic            w_drop;
  logic            w_baud_last;

  // Occupancy flags come from the pointers as they stand at the start of the
  // cycle; the extra wrap bit separates full from empty.
  assign w_empty     = (wptr_q == rptr_q);
  assign w_full      = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_push      = Dval & ~dval_q;
  assign w_pop       = (state_q == IDLE) & ~w_empty;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts the byte in that case.
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_baud_last = (cnt_q == CNT_LAST);

  assign Tx       = tx_q;
  assign Busy     = busy_q;
  assign Overflow = overflow_q;
  assign Count    = wptr_q - rptr_q;

  // Dval edge detector: one push per low-to-high transition of the level.
  always_ff @(posedge Clock) begin
    if (Reset) dval_q <= 1'b0;
    else       dval_q <= Dval;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge Clock) begin
    if (w_wr) mem_q[wptr_q[AW-1:0]] <= Dout;
  end

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_wr)   wptr_q     <= wptr_q + PTR_ONE;
      if (w_pop)  rptr_q     <= rptr_q + PTR_ONE;
      if (w_drop) overflow_q <= 1'b1;
    end
  end

  // Serial framer: Tx and Busy are registered from the state seen this cycle,
  // so the line lags the state decision by one clock.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      busy_q <= (state_q != IDLE) | ~w_empty;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!w_empty) begin
            shift_q <= mem_q[rptr_q[AW-1:0]];
`ifdef PARITY_EN
            par_q   <= ^mem_q[rptr_q[AW-1:0]];
`endif
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (w_baud_last) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (w_baud_last) begin
            cnt_q   <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          tx_q <= par_q;
          if (w_baud_last) begin
            cnt_q   <= '0;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (w_baud_last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dout_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dout_uart_tx
//  Purpose  : Directed self-checking bench for dout_uart_tx (DIV=10, DEPTH=8).
//             Honours PARITY_EN for the 8E1 build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dout_uart_tx;

  localparam int DIV = 10;
`ifdef PARITY_EN
  localparam int FRAME = 11 * DIV + 1;
`else
  localparam int FRAME = 10 * DIV + 1;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Dout  = 8'h00;
  logic       Dval  = 1'b0;
  logic       Tx;
  logic       Busy;
  logic       Overflow;
  logic [3:0] Count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit scramble = 1'b0;

  dout_uart_tx #(
    .CLK_HZ (1000),
    .BAUD   (100),
    .DEPTH  (8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Dout     (Dout),
    .Dval     (Dval),
    .Tx       (Tx),
    .Busy     (Busy),
    .Overflow (Overflow),
    .Count    (Count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; all sampling and driving happens 1 ns after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
    if (scramble) Dout = 8'($urandom);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  // One-clock Dval pulse; returns the edge number at which it is pushed.
  task automatic pulse(input logic [7:0] d, output int e);
    Dout = d;
    Dval = 1'b1;
    step();
    e = cyc;
    Dval = 1'b0;
    step();
  endtask

  // Checks the frame whose pop happens at edge p (Tx falls at p+1).
  task automatic check_frame(input int p, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    got = 8'h00;
    wait_cyc(p + 1);
    chk({tag, "_start_first"}, Tx, 0);
    wait_cyc(p + DIV);
    chk({tag, "_start_last"}, Tx, 0);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(p + DIV * (i + 1) + DIV / 2);
      got[i] = Tx;
    end
    chk({tag, "_data"}, got, exp);
`ifdef PARITY_EN
    wait_cyc(p + 9 * DIV + DIV / 2);
    chk({tag, "_parity"}, Tx, ^exp);
    wait_cyc(p + 10 * DIV + DIV / 2);
    chk({tag, "_stop"}, Tx, 1);
`else
    wait_cyc(p + 9 * DIV + DIV / 2);
    chk({tag, "_stop"}, Tx, 1);
`endif
  endtask

  initial begin
    int n;
    int q;
    int r;
    int s;
    int t;
    int e;
    bit seen;

    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_tx", Tx, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_count", Count, 0);
    Reset = 1'b0;
    wait_cyc(4);

    // ---------------- single byte 0xA5 ----------------
    Dout = 8'hA5;
    Dval = 1'b1;
    step();
    n = cyc;
    Dval = 1'b0;
    chk("t1_count_peak", Count, 1);
    step();
    chk("t1_count_popped", Count, 0);
    chk("t1_busy", Busy, 1);
    chk("t1_tx_idle_at_pop", Tx, 1);
    check_frame(n + 1, 8'hA5, "t1");
    wait_cyc(n + FRAME);
    chk("t1_busy_last", Busy, 1);
    step();
    chk("t1_busy_end", Busy, 0);
    chk("t1_tx_end", Tx, 1);

    // ---------------- level hold ----------------
    step();
    Dout = 8'h5A;
    Dval = 1'b1;
    step();
    n = cyc;
    scramble = 1'b1;
    check_frame(n + 1, 8'h5A, "hold");
    wait_cyc(n + FRAME + 1);
    chk("hold_busy_end", Busy, 0);
    seen = 1'b0;
    while (cyc < n + 500) begin
      step();
      if (Tx !== 1'b1 || Count !== 4'd0 || Busy !== 1'b0) seen = 1'b1;
    end
    chk("hold_single_frame", seen, 0);
    scramble = 1'b0;
    Dval = 1'b0;
    step();

    // ---------------- overflow ----------------
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    pulse(8'h01, q);
    for (int k = 2; k <= 10; k++) pulse(8'(k), e);
    chk("ovf_count_full", Count, 8);
    chk("ovf_flag", Overflow, 1);
    for (int k = 1; k <= 8; k++)
      check_frame(q + 1 + FRAME * k, 8'(k + 1), "ovf");
    wait_cyc(q + 1 + FRAME * 9);
    chk("ovf_busy_drained", Busy, 0);
    chk("ovf_count_drained", Count, 0);
    chk("ovf_sticky", Overflow, 1);
    wait_cyc(q + 3 + FRAME * 9);
    chk("ovf_no_tenth", Tx, 1);

    // ---------------- full with simultaneous pop ----------------
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    chk("fp_ovf_cleared", Overflow, 0);
    pulse(8'h11, r);
    for (int j = 0; j < 8; j++) pulse(8'h20 + 8'(j), e);
    chk("fp_count_full", Count, 8);
    wait_cyc(r + FRAME);
    chk("fp_count_before", Count, 8);
    Dout = 8'h30;
    Dval = 1'b1;
    step();
    Dval = 1'b0;
    chk("fp_count_kept", Count, 8);
    chk("fp_no_overflow", Overflow, 0);
    check_frame(r + 1 + FRAME, 8'h20, "fp_first");
    check_frame(r + 1 + FRAME * 9, 8'h30, "fp_last");
    wait_cyc(r + 1 + FRAME * 10);
    chk("fp_drained", Count, 0);

    // ---------------- reset mid-frame ----------------
    step();
    pulse(8'h81, s);
    pulse(8'h55, e);
    pulse(8'h66, e);
    wait_cyc(s + 44);
    chk("mid_tx_bit3", Tx, 0);
    chk("mid_count", Count, 2);
    Reset = 1'b1;
    step();
    chk("mid_tx_high", Tx, 1);
    chk("mid_count_clr", Count, 0);
    chk("mid_busy_clr", Busy, 0);
    chk("mid_ovf_clr", Overflow, 0);
    Reset = 1'b0;
    step();
    step();
    chk("mid_stays_idle", Tx, 1);
    pulse(8'h3C, t);
    check_frame(t + 1, 8'h3C, "post");
    wait_cyc(t + FRAME + 1);
    chk("post_busy_end", Busy, 0);

`ifdef PARITY_EN
    // ---------------- parity frame ----------------
    pulse(8'h07, t);
    check_frame(t + 1, 8'h07, "par");
    wait_cyc(t + FRAME);
    chk("par_busy_last", Busy, 1);
    step();
    chk("par_busy_end", Busy, 0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
